// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM state encoding and default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin (mod 2), bout set when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first: one full-subtractor cell iterated over WIDTH clock edges.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shift_a_q, shift_b_q, shift_d_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;

  logic               d_bit, bo_bit;
  logic               accept;
  logic               last_bit;

  full_subtractor u_cell (
    .a    (shift_a_q[0]),
    .b    (shift_b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_BIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured on accept; results update only on the final bit so they stay stable during RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      shift_d_q <= '0;
      borrow_q  <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      shift_a_q <= i_a;
      shift_b_q <= i_b;
      shift_d_q <= '0;
      borrow_q  <= i_bin;
    end else if (state_q == ST_RUN) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      shift_a_q <= {1'b0, shift_a_q[WIDTH-1:1]};
      shift_b_q <= {1'b0, shift_b_q[WIDTH-1:1]};
      shift_d_q <= {d_bit, shift_d_q[WIDTH-1:1]};
      borrow_q  <= bo_bit;
      if (last_bit) begin
        diff_q <= {d_bit, shift_d_q[WIDTH-1:1]};
        bout_q <= bo_bit;
      end
    end
  end

  assign o_diff = diff_q;
  assign o_bout = bout_q;

endmodule
